rv_decode_stage: RTL

Registered RV32I decode stage with valid/ready handshake, placed between instruction fetch and the register-file/ALU issue logic. It decodes all RV32I base-format immediates (I/S/B/U/J), produces register addresses, ALU control and write-enable, and buffers results in a two-entry skid buffer so fetch sees a registered ready with no throughput loss. The width is parametrised through XLEN, and a synchronous flush supports branch redirect.

---
 rtl/rv_decode_stage_if.sv | 44 ++++
 rtl/rv_decode_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_decode_stage_if.sv
// rtl/rv_decode_stage_if.sv - fetch-side and issue-side handshake bundle of rv_decode_stage
interface rv_decode_stage_if #(
  parameter int XLEN = 32
);
  // fetch side
  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] pc_i;

  // issue side
  logic            out_valid_o;
  logic            out_ready_i;
  logic [XLEN-1:0] pc_o;
  logic [4:0]      rs_addr_a_o;
  logic [4:0]      rs_addr_b_o;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] imm_o;
  logic            alu_src_o;
  logic [3:0]      alu_op_o;
  logic [2:0]      funct3_o;
  logic            is_branch_o;
  logic            is_jump_o;
  logic            is_load_o;
  logic            is_store_o;
  logic            rd_we_o;
  logic            illegal_o;

  // decode stage view
  modport slave (
    input  in_valid_i, instr_i, pc_i, out_ready_i,
    output in_ready_o, out_valid_o, pc_o, rs_addr_a_o, rs_addr_b_o, rd_addr_o,
           imm_o, alu_src_o, alu_op_o, funct3_o, is_branch_o, is_jump_o,
           is_load_o, is_store_o, rd_we_o, illegal_o
  );

  // fetch/issue environment view
  modport master (
    output in_valid_i, instr_i, pc_i, out_ready_i,
    input  in_ready_o, out_valid_o, pc_o, rs_addr_a_o, rs_addr_b_o, rd_addr_o,
           imm_o, alu_src_o, alu_op_o, funct3_o, is_branch_o, is_jump_o,
           is_load_o, is_store_o, rd_we_o, illegal_o
  );
endinterface

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - registered RV32I decode with two-entry skid buffer; RV_DECODE_ILLEGAL_EN enables legality checking
module rv_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  rv_decode_stage_if.slave bus
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // One decoded instruction as it sits in either buffer entry.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs_a;
    logic [4:0]      rs_b;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            alu_src;
    logic [3:0]      alu_op;
    logic [2:0]      funct3;
    logic            is_branch;
    logic            is_jump;
    logic            is_load;
    logic            is_store;
    logic            rd_we;
    logic            illegal;
  } dec_t;

  // Immediates are assembled at 32 bits and then sign-extended to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return XLEN'($signed(v));
  endfunction

  // instr[30] picks SUB only for register-register ops, SRA for both shift forms.
  function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic alt,
                                                input logic is_reg);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic            illegal_w;
  dec_t            dec;

  assign instr  = bus.instr_i;
  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  assign imm_i = sext32({{20{instr[31]}}, instr[31:20]});
  assign imm_s = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
  assign imm_b = sext32({{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0});
  assign imm_u = sext32({instr[31:12], 12'b0});
  assign imm_j = sext32({{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0});

`ifdef RV_DECODE_ILLEGAL_EN
  logic [6:0] funct7;
  assign funct7 = instr[31:25];

  // Legality of the RV32I base encodings; any opcode outside the nine classes is illegal.
  always_comb begin
    illegal_w = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC, OPC_JAL: illegal_w = 1'b0;
      OPC_JALR:   illegal_w = (funct3 != 3'b000);
      OPC_BRANCH: illegal_w = (funct3 == 3'b010) || (funct3 == 3'b011);
      OPC_LOAD:   illegal_w = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      OPC_STORE:  illegal_w = (funct3 > 3'b010);
      OPC_OP_IMM: begin
        if (funct3 == 3'b001) begin
          illegal_w = (funct7 != 7'b0000000);
        end else if (funct3 == 3'b101) begin
          illegal_w = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
        end
      end
      OPC_OP: illegal_w = !((funct7 == 7'b0000000) ||
                            ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      default: illegal_w = 1'b1;
    endcase
  end
`else
  assign illegal_w = 1'b0;
`endif

  // Combinational decode of the incoming word into a buffer entry.
  always_comb begin
    dec        = '0;
    dec.pc     = bus.pc_i;
    dec.rs_a   = instr[19:15];
    dec.rs_b   = instr[24:20];
    dec.rd     = instr[11:7];
    dec.funct3 = funct3;
    case (opcode)
      OPC_LUI: begin
        dec.imm = imm_u; dec.alu_op = ALU_PASSB; dec.alu_src = 1'b1; dec.rd_we = 1'b1;
      end
      OPC_AUIPC: begin
        dec.imm = imm_u; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.rd_we = 1'b1;
      end
      OPC_JAL: begin
        dec.imm = imm_j; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1;
        dec.is_jump = 1'b1; dec.rd_we = 1'b1;
      end
      OPC_JALR: begin
        dec.imm = imm_i; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1;
        dec.is_jump = 1'b1; dec.rd_we = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm = imm_b; dec.alu_op = ALU_SUB; dec.is_branch = 1'b1;
      end
      OPC_LOAD: begin
        dec.imm = imm_i; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1;
        dec.is_load = 1'b1; dec.rd_we = 1'b1;
      end
      OPC_STORE: begin
        dec.imm = imm_s; dec.alu_op = ALU_ADD; dec.alu_src = 1'b1; dec.is_store = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.imm = imm_i; dec.alu_op = alu_from_funct(funct3, instr[30], 1'b0);
        dec.alu_src = 1'b1; dec.rd_we = 1'b1;
      end
      OPC_OP: begin
        dec.alu_op = alu_from_funct(funct3, instr[30], 1'b1); dec.rd_we = 1'b1;
      end
      default: dec.rd_we = 1'b0;
    endcase
    dec.illegal = illegal_w;
    if (illegal_w) begin
      dec.rd_we     = 1'b0;
      dec.is_branch = 1'b0;
      dec.is_jump   = 1'b0;
      dec.is_load   = 1'b0;
      dec.is_store  = 1'b0;
    end
    if (dec.rd == 5'd0) begin
      dec.rd_we = 1'b0;
    end
  end

  dec_t out_q, out_d;
  dec_t skid_q, skid_d;
  logic out_valid_q, out_valid_d;
  logic skid_valid_q, skid_valid_d;
  logic in_ready_q;
  logic accept;
  logic out_free;

  assign accept   = bus.in_valid_i && in_ready_q;
  assign out_free = !out_valid_q || bus.out_ready_i;

  // Buffer steering: OUT refills from SKID first, fetch data fills whichever slot is free.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = accept;
        if (accept) begin
          skid_d = dec;
        end
      end else begin
        out_valid_d = accept;
        if (accept) begin
          out_d = dec;
        end
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // Buffer state; in_ready is registered from the next SKID occupancy so fetch never sees out_ready_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.pc_o        = out_q.pc;
  assign bus.rs_addr_a_o = out_q.rs_a;
  assign bus.rs_addr_b_o = out_q.rs_b;
  assign bus.rd_addr_o   = out_q.rd;
  assign bus.imm_o       = out_q.imm;
  assign bus.alu_src_o   = out_q.alu_src;
  assign bus.alu_op_o    = out_q.alu_op;
  assign bus.funct3_o    = out_q.funct3;
  assign bus.is_branch_o = out_q.is_branch;
  assign bus.is_jump_o   = out_q.is_jump;
  assign bus.is_load_o   = out_q.is_load;
  assign bus.is_store_o  = out_q.is_store;
  assign bus.rd_we_o     = out_q.rd_we;
  assign bus.illegal_o   = out_q.illegal;

endmodule
